// File: rtl/fpu_conv_pkg.sv
// Shared definitions for the float-to-integer converter: FSM states,
// rounding modes, flag bit positions and exponent bias.
package fpu_conv_pkg;

  typedef enum logic [2:0] {
    S_GET_A,
    S_UNPACK,
    S_SPECIAL,
    S_CONVERT,
    S_ROUND,
    S_PUT_Z
  } conv_state_e;

  localparam bit ROUND_TRUNC = 1'b0;
  localparam bit ROUND_RNE   = 1'b1;

  localparam int FLAG_INVALID = 0;
  localparam int FLAG_INEXACT = 1;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [1:0] mk_flags(input logic invalid, input logic inexact);
    logic [1:0] f;
    f = '0;
    f[FLAG_INVALID] = invalid;
    f[FLAG_INEXACT] = inexact;
    return f;
  endfunction

endpackage

// File: rtl/float_int_round.sv
// Rounds an integer magnitude with guard/sticky and range-checks it
// against the signed or unsigned destination format.
module float_int_round
  import fpu_conv_pkg::*;
#(
  parameter int INT_W      = 64,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic [INT_W-1:0] int_part,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  logic             mode,
  output logic [INT_W-1:0] mag,
  output logic             overflow,
  output logic             inexact
);

  logic             inc;
  logic [INT_W:0]   sum;

  assign inc     = (mode == ROUND_RNE) && guard && (sticky || int_part[0]);
  assign sum     = {1'b0, int_part} + {{INT_W{1'b0}}, inc};
  assign mag     = sum[INT_W-1:0];
  assign inexact = guard | sticky;

  // Negative side of a signed result may reach exactly 2^(INT_W-1).
  always_comb begin
    if (SIGNED_OUT)
      overflow = sum[INT_W] | (sign ? (sum[INT_W-1] & (|sum[INT_W-2:0])) : sum[INT_W-1]);
    else
      overflow = sum[INT_W] | (sign & (|sum[INT_W-1:0]));
  end

endmodule

// File: rtl/float_to_int_conv.sv
// IEEE-754 float to signed/unsigned integer converter with stb/ack
// streaming handshake, truncate or round-to-nearest-even.
module float_to_int_conv
  import fpu_conv_pkg::*;
#(
  parameter int EXP_W      = 11,
  parameter int MAN_W      = 52,
  parameter int INT_W      = 64,
  parameter bit SIGNED_OUT = 1'b1,
  parameter int ROUND      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  output logic [INT_W-1:0]       output_z,
  output logic                   output_z_stb,
  input  logic                   output_z_ack,
  output logic [1:0]             output_flags
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int WW   = INT_W + MAN_W + 1;
  localparam int SHW  = $clog2(INT_W + 1);
  localparam logic [INT_W-1:0] INV_PAT =
    SIGNED_OUT ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b1}};

  conv_state_e             state;
  logic [EXP_W+MAN_W:0]    a_q;
  logic                    sgn;
  logic [EXP_W-1:0]        exp_f;
  logic [MAN_W-1:0]        man_f;
  logic [MAN_W:0]          sig;
  logic signed [EXP_W+1:0] ue;
  logic [INT_W+1:0]        fld;
  logic [INT_W+1:0]        fld_c;
  logic [WW-1:0]           wide;
  logic [SHW-1:0]          sh;
  logic [INT_W-1:0]        rnd_mag;
  logic                    rnd_ovf, rnd_inx;

  // Binary point of wide sits at bit MAN_W+1; everything below one half
  // (ue < -1) collapses to a pure sticky bit.
  assign sh = SHW'(int'(ue) + 1);

  always_comb begin
    wide  = '0;
    fld_c = {{INT_W{1'b0}}, 2'b01};
    if (int'(ue) >= -1) begin
      wide  = {{INT_W{1'b0}}, sig} << sh;
      fld_c = {wide[WW-1:MAN_W+1], wide[MAN_W], |wide[MAN_W-1:0]};
    end
  end

  float_int_round #(
    .INT_W      (INT_W),
    .SIGNED_OUT (SIGNED_OUT)
  ) u_round (
    .int_part (fld[INT_W+1:2]),
    .guard    (fld[1]),
    .sticky   (fld[0]),
    .sign     (sgn),
    .mode     ((ROUND != 0) ? ROUND_RNE : ROUND_TRUNC),
    .mag      (rnd_mag),
    .overflow (rnd_ovf),
    .inexact  (rnd_inx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
    end else begin
      case (state)
        S_GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_q         <= input_a;
            input_a_ack <= 1'b0;
            state       <= S_UNPACK;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        S_UNPACK: begin
          sgn   <= a_q[EXP_W+MAN_W];
          exp_f <= a_q[MAN_W +: EXP_W];
          man_f <= a_q[MAN_W-1:0];
          sig   <= {|a_q[MAN_W +: EXP_W], a_q[MAN_W-1:0]};
          ue    <= $signed({2'b00, a_q[MAN_W +: EXP_W]}) - $signed((EXP_W+2)'(BIAS));
          state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          state <= S_PUT_Z;
          if (&exp_f) begin
            output_z     <= INV_PAT;
            output_flags <= mk_flags(1'b1, 1'b0);
          end else if (exp_f == '0) begin
            output_z     <= '0;
            output_flags <= mk_flags(1'b0, |man_f);
          end else if (int'(ue) >= INT_W) begin
            output_z     <= INV_PAT;
            output_flags <= mk_flags(1'b1, 1'b0);
          end else if (SIGNED_OUT && sgn && int'(ue) == INT_W - 1 && man_f == '0) begin
            output_z     <= INV_PAT;
            output_flags <= mk_flags(1'b0, 1'b0);
          end else begin
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          fld   <= fld_c;
          state <= S_ROUND;
        end
        S_ROUND: begin
          output_z     <= rnd_ovf ? INV_PAT : (sgn ? -rnd_mag : rnd_mag);
          output_flags <= mk_flags(rnd_ovf, rnd_inx & ~rnd_ovf);
          state        <= S_PUT_Z;
        end
        S_PUT_Z: begin
          output_z_stb <= 1'b1;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= S_GET_A;
          end
        end
        default: state <= S_GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_conv.sv
// Bench for float_to_int_conv: directed vectors, real-valued reference
// model for random doubles, handshake/reset corners, rounding unit table.
module tb_float_to_int_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb_drv, sel32, zack;
  logic [63:0] a_bus;
  logic        stb_d, stb_s, ack_m, zstb_m;
  logic        ack_d, ack_r, ack_s, zstb_d, zstb_r, zstb_s;
  logic [63:0] z_d, z_r;
  logic [15:0] z_s;
  logic [1:0]  f_d, f_r, f_s;

  assign stb_d  = stb_drv & ~sel32;
  assign stb_s  = stb_drv & sel32;
  assign ack_m  = sel32 ? ack_s : ack_d;
  assign zstb_m = sel32 ? zstb_s : zstb_d;

  float_to_int_conv u_d (
    .clk(clk), .rst(rst), .input_a(a_bus), .input_a_stb(stb_d), .input_a_ack(ack_d),
    .output_z(z_d), .output_z_stb(zstb_d), .output_z_ack(zack), .output_flags(f_d));

  float_to_int_conv #(.ROUND(1)) u_r (
    .clk(clk), .rst(rst), .input_a(a_bus), .input_a_stb(stb_d), .input_a_ack(ack_r),
    .output_z(z_r), .output_z_stb(zstb_r), .output_z_ack(zack), .output_flags(f_r));

  float_to_int_conv #(.EXP_W(8), .MAN_W(23), .INT_W(16), .SIGNED_OUT(1'b0)) u_s (
    .clk(clk), .rst(rst), .input_a(a_bus[31:0]), .input_a_stb(stb_s), .input_a_ack(ack_s),
    .output_z(z_s), .output_z_stb(zstb_s), .output_z_ack(zack), .output_flags(f_s));

  // Standalone rounding unit, 8-bit signed.
  logic [7:0] r_int, r_mag;
  logic       r_g, r_s, r_sg, r_md, r_ovf, r_inx;
  float_int_round #(.INT_W(8), .SIGNED_OUT(1'b1)) u_rnd (
    .int_part(r_int), .guard(r_g), .sticky(r_s), .sign(r_sg), .mode(r_md),
    .mag(r_mag), .overflow(r_ovf), .inexact(r_inx));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input bit s32);
    int n = 0;
    sel32 = s32; a_bus = a; stb_drv = 1'b1;
    while (!ack_m && n < 20) begin @(negedge clk); n++; end
    check("send_ack", ack_m, 1);
    @(negedge clk);
    stb_drv = 1'b0;
  endtask

  task automatic get(output int lat);
    lat = 0;
    while (!zstb_m && lat < 20) begin @(negedge clk); lat++; end
  endtask

  localparam real P63 = 9223372036854775808.0;

  function automatic void ref_d(input logic [63:0] b, input bit rne,
                                output logic [63:0] z, output logic [1:0] f);
    real v, fl, r;
    z = 64'h8000_0000_0000_0000; f = 2'b01;
    if (b[62:52] == 11'h7ff) return;
    v  = $bitstoreal(b);
    fl = $floor(v);
    if (rne) begin
      r = fl;
      if ((v - fl > 0.5) || (v - fl == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) r = fl + 1.0;
    end else begin
      r = (v < 0.0) ? $ceil(v) : fl;
    end
    if (r >= P63 || r < -P63) return;
    z = (r == -P63) ? 64'h8000_0000_0000_0000 : 64'(longint'(r));
    f = {(r != v), 1'b0};
  endfunction

  typedef struct {
    bit          s32;
    logic [63:0] a;
    logic [63:0] zd;
    logic [1:0]  fd;
    logic [63:0] zr;
    logic [1:0]  fr;
    int          lat;
  } vec_t;

  typedef struct {
    logic [7:0] ip; logic g, s, sg, md;
    logic [7:0] mag; logic ovf, inx;
  } rvec_t;

  vec_t  tv[16];
  rvec_t rv[8];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          ok;
    logic [63:0] a, z0, ez, er, msk;
    logic [1:0]  efd, efr;

    tv[0]  = '{0, 64'h3FF0000000000000, 64'd1, 2'b00, 64'd1, 2'b00, 5};
    tv[1]  = '{0, 64'hC004000000000000, 64'hFFFFFFFFFFFFFFFE, 2'b10, 64'hFFFFFFFFFFFFFFFE, 2'b10, 5};
    tv[2]  = '{0, 64'h400C000000000000, 64'd3, 2'b10, 64'd4, 2'b10, 5};
    tv[3]  = '{0, 64'h4004000000000000, 64'd2, 2'b10, 64'd2, 2'b10, 5};
    tv[4]  = '{0, 64'h7FF8000000000000, 64'h8000000000000000, 2'b01, 64'h8000000000000000, 2'b01, 3};
    tv[5]  = '{0, 64'h43E0000000000000, 64'h8000000000000000, 2'b01, 64'h8000000000000000, 2'b01, 5};
    tv[6]  = '{0, 64'hC3E0000000000000, 64'h8000000000000000, 2'b00, 64'h8000000000000000, 2'b00, 3};
    tv[7]  = '{0, 64'h0000000000000000, 64'd0, 2'b00, 64'd0, 2'b00, 3};
    tv[8]  = '{0, 64'h8000000000000001, 64'd0, 2'b10, 64'd0, 2'b10, 3};
    tv[9]  = '{0, 64'h3FE0000000000000, 64'd0, 2'b10, 64'd0, 2'b10, 5};
    tv[10] = '{0, 64'hFFF0000000000000, 64'h8000000000000000, 2'b01, 64'h8000000000000000, 2'b01, 3};
    tv[11] = '{1, 64'h477FFF00, 64'hFFFF, 2'b00, 64'd0, 2'b00, 5};
    tv[12] = '{1, 64'h47800000, 64'hFFFF, 2'b01, 64'd0, 2'b00, 3};
    tv[13] = '{1, 64'hBF800000, 64'hFFFF, 2'b01, 64'd0, 2'b00, 5};
    tv[14] = '{1, 64'hBE800000, 64'h0000, 2'b10, 64'd0, 2'b00, 5};
    tv[15] = '{1, 64'h3FC00000, 64'h0001, 2'b10, 64'd0, 2'b00, 5};

    rv[0] = '{8'd3,   1, 0, 0, 1, 8'd4,   0, 1};
    rv[1] = '{8'd2,   1, 0, 0, 1, 8'd2,   0, 1};
    rv[2] = '{8'd2,   1, 1, 0, 0, 8'd2,   0, 1};
    rv[3] = '{8'd127, 1, 1, 0, 1, 8'd128, 1, 1};
    rv[4] = '{8'd127, 1, 1, 1, 1, 8'd128, 0, 1};
    rv[5] = '{8'd255, 1, 0, 0, 1, 8'd0,   1, 1};
    rv[6] = '{8'd5,   0, 0, 1, 0, 8'd5,   0, 0};
    rv[7] = '{8'd128, 0, 1, 1, 0, 8'd128, 0, 1};

    for (int i = 0; i < 8; i++) begin
      {r_int, r_g, r_s, r_sg, r_md} = {rv[i].ip, rv[i].g, rv[i].s, rv[i].sg, rv[i].md};
      #1;
      check($sformatf("rnd%0d", i), {r_mag, r_ovf, r_inx}, {rv[i].mag, rv[i].ovf, rv[i].inx});
    end

    rst = 1'b1; zack = 1'b1; stb_drv = 1'b0; sel32 = 1'b0; a_bus = '0;
    repeat (3) @(negedge clk);
    check("reset_d", {ack_d, zstb_d, z_d, f_d}, '0);
    check("reset_s", {ack_s, zstb_s, z_s, f_s}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("ack_after_reset", ack_d, 1);

    for (int i = 0; i < 16; i++) begin
      send(tv[i].a, tv[i].s32);
      get(lat);
      check($sformatf("lat%0d", i), lat, tv[i].lat);
      if (tv[i].s32)
        check($sformatf("vec%0d_s", i), {f_s, z_s}, {tv[i].fd, tv[i].zd[15:0]});
      else begin
        check($sformatf("vec%0d_d", i), {f_d, z_d}, {tv[i].fd, tv[i].zd});
        check($sformatf("vec%0d_r", i), {zstb_r, f_r, z_r}, {1'b1, tv[i].fr, tv[i].zr});
      end
    end

    // Output backpressure: result frozen, no new operand accepted.
    @(negedge clk);
    zack = 1'b0;
    send(64'h3FF0000000000000, 0);
    get(lat);
    z0 = z_d; ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!zstb_d || ack_d || z_d !== z0) ok = 1'b0;
    end
    check("bp_hold", ok, 1);
    check("bp_value", z_d, 64'd1);
    zack = 1'b1;
    @(negedge clk);
    check("bp_release", {zstb_d, ack_d}, 2'b01);

    // Reset while the conversion sits in CONVERT.
    send(64'h4014000000000000, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {zstb_d, ack_d}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", ack_d, 1);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (zstb_d) ok = 1'b0;
    end
    check("rst_no_stale", ok, 1);
    send(64'h3FF0000000000000, 0);
    get(lat);
    check("rst_then_one", {f_d, z_d}, {2'b00, 64'd1});

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a = {$urandom, $urandom};
      a[62:52] = 11'(1023 + $urandom_range(0, 140) - 70);
      if (k % 16 == 0) a[62:52] = 11'h000;
      if (k % 16 == 1) a[62:52] = 11'h7FF;
      if ($urandom_range(0, 1) == 1) begin
        msk = (64'd1 << $urandom_range(0, 52)) - 64'd1;
        a[51:0] = a[51:0] & ~msk[51:0];
      end
      ref_d(a, 1'b0, ez, efd);
      ref_d(a, 1'b1, er, efr);
      send(a, 0);
      get(lat);
      check($sformatf("rand%0d_d a=%h", k, a), {zstb_d, f_d, z_d}, {1'b1, efd, ez});
      check($sformatf("rand%0d_r a=%h", k, a), {zstb_r, f_r, z_r}, {1'b1, efr, er});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
